// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Combinational IF lookup; EX-stage training and a registered mispredict redirect.
module branch_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IF_PC,
  output logic        PRED_TAKEN,
  output logic [31:0] PRED_TARGET,
  input  logic        EX_VALID,
  input  logic [31:0] EX_PC,
  input  logic        EX_IS_BRANCH,
  input  logic        EX_TAKEN,
  input  logic [31:0] EX_TARGET,
  input  logic        EX_PRED_TAKEN,
  input  logic [31:0] EX_PRED_TARGET,
  output logic        MISPREDICT,
  output logic [31:0] REDIRECT_PC
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]               r_valid;
  logic [ENTRIES-1:0][1:0]          r_ctr;
  logic [ENTRIES-1:0][TAG_BITS-1:0] r_tag;
  logic [ENTRIES-1:0][31:0]         r_target;

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0]   w_if_tag;
  logic                  w_if_hit;
  logic [INDEX_BITS-1:0] w_ex_idx;
  logic [TAG_BITS-1:0]   w_ex_tag;
  logic                  w_ex_hit;
  logic                  w_br_miss;
  logic                  w_mispred;
  logic [31:0]           w_correct_pc;
  logic [1:0]            w_ctr_cur;

  // Lookup reads the pre-update table; there is deliberately no EX->IF bypass.
  assign w_if_idx    = IF_PC[INDEX_BITS+1:2];
  assign w_if_tag    = IF_PC[31:INDEX_BITS+2];
  assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign PRED_TAKEN  = w_if_hit && r_ctr[w_if_idx][1];
  assign PRED_TARGET = w_if_hit ? r_target[w_if_idx] : 32'd0;

  assign w_ex_idx  = EX_PC[INDEX_BITS+1:2];
  assign w_ex_tag  = EX_PC[31:INDEX_BITS+2];
  assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ctr_cur = r_ctr[w_ex_idx];

  assign w_br_miss = (EX_TAKEN != EX_PRED_TAKEN) ||
                     (EX_TAKEN && EX_PRED_TAKEN && (EX_TARGET != EX_PRED_TARGET));
  // A non-branch that was predicted taken means fetch followed an aliased entry.
  assign w_mispred    = EX_VALID && (EX_IS_BRANCH ? w_br_miss : EX_PRED_TAKEN);
  assign w_correct_pc = (EX_TAKEN && EX_IS_BRANCH) ? EX_TARGET : (EX_PC + 32'd4);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_ctr[i]    <= 2'b01;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
      MISPREDICT  <= 1'b0;
      REDIRECT_PC <= 32'd0;
    end else begin
      MISPREDICT <= w_mispred;
      if (w_mispred) REDIRECT_PC <= w_correct_pc;
      if (EX_VALID) begin
        if (EX_IS_BRANCH) begin
          if (w_ex_hit) begin
            if (EX_TAKEN) begin
              if (w_ctr_cur != 2'b11) r_ctr[w_ex_idx] <= w_ctr_cur + 2'd1;
              r_target[w_ex_idx] <= EX_TARGET;
            end else if (w_ctr_cur != 2'b00) begin
              r_ctr[w_ex_idx] <= w_ctr_cur - 2'd1;
            end
          end else if (EX_TAKEN) begin
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= EX_TARGET;
            r_ctr[w_ex_idx]    <= 2'b10;
          end
        end else if (w_ex_hit) begin
          r_valid[w_ex_idx] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating counters. It sits between fetch (IF) and execute (EX) in the CPU pipeline. In IF it gives a taken/target prediction for the fetch PC. In EX it takes the resolved outcome from the branch-compare unit, trains the table, and raises a registered mispredict redirect for the PC mux and the pipeline flush logic.

## Interface
- INDEX_BITS, 4: table has 2^INDEX_BITS entries, indexed by PC[INDEX_BITS+1:2].
- TAG_BITS, 30-INDEX_BITS: tag is PC[31:INDEX_BITS+2] (derived; do not override).

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RESET  in  1  asynchronous, active-high.
- IF_PC  in  32  fetch-stage PC.
- PRED_TAKEN  out  1  combinational: predicted taken for IF_PC.
- PRED_TARGET  out  32  combinational: predicted target; valid only when PRED_TAKEN=1.
- EX_VALID  in  1  EX stage holds a real instruction (not a bubble or flushed).
- EX_PC  in  32  PC of the EX instruction.
- EX_IS_BRANCH  in  1  EX instruction is a branch, JAL or JALR (branch-select enable bit set).
- EX_TAKEN  in  1  resolved outcome from the branch-compare unit.
- EX_TARGET  in  32  resolved target address.
- EX_PRED_TAKEN  in  1  PRED_TAKEN carried down the pipe for this instruction.
- EX_PRED_TARGET  in  32  PRED_TARGET carried down the pipe.
- MISPREDICT  out  1  registered, one-cycle pulse: redirect fetch and flush the younger stages.
- REDIRECT_PC  out  32  registered: correct next PC; meaningful when MISPREDICT=1.

## Operation
- Each entry holds: valid, tag, target[31:0], ctr[1:0].
- Lookup:
  - hit = valid && tag==IF_PC tag.
  - PRED_TAKEN = hit && ctr[1].
  - PRED_TARGET = entry target.
  - On a miss, PRED_TAKEN=0 and PRED_TARGET=0.
- Update only when EX_VALID=1. Use idx and tag of EX_PC.
  - EX_IS_BRANCH=1, hit: ctr saturates up on taken (max 11) and down on not-taken (min 00). On taken, target <= EX_TARGET.
  - EX_IS_BRANCH=1, miss, taken: allocate. valid=1, tag, target=EX_TARGET, ctr=10 (replaces any prior occupant).
  - EX_IS_BRANCH=1, miss, not-taken: no table change.
  - EX_IS_BRANCH=0, hit: invalidate the entry (alias cleanup). Otherwise no change.
- Mispredict condition (cond), only when EX_VALID=1:
  - EX_IS_BRANCH=1: EX_TAKEN != EX_PRED_TAKEN, or (EX_TAKEN && EX_PRED_TAKEN && EX_TARGET != EX_PRED_TARGET).
  - EX_IS_BRANCH=0: EX_PRED_TAKEN=1.
- Correct PC = EX_TAKEN && EX_IS_BRANCH ? EX_TARGET : EX_PC+4 (32-bit, wraps modulo 2^32).
- JAL/JALR arrive with EX_TAKEN=1 and train like any taken branch.

## Timing
- Lookup: zero-cycle combinational from IF_PC and table state.
- Table write occurs at the CLK edge that ends the EX cycle.
- Same-index lookup and update in one cycle: the lookup sees pre-update contents. No bypass.
- MISPREDICT and REDIRECT_PC are registered at the same edge as the table write. They are valid the cycle after EX and last exactly one cycle.
  - If cond is false on the next edge, MISPREDICT returns to 0 and REDIRECT_PC holds its last value.
- Back-to-back mispredicts produce back-to-back pulses. The pipeline guarantees the second EX instruction is flushed (EX_VALID=0) in the redirect cycle, so this case only arises from the bench.
- RESET assertion, at any time including mid-update, asynchronously sets:
  - all valid bits = 0 and all ctr = 01;
  - MISPREDICT = 0 and REDIRECT_PC = 0.
  - Target and tag contents are don't-care and may be left unreset.
  - No update is performed in any cycle where RESET is high.
- EX_VALID=0: no table change, MISPREDICT=0 at the next edge.

## Test plan
- After reset, IF_PC=0x100 -> PRED_TAKEN=0. EX PC=0x100, branch, taken, target 0x80, pred 0 -> next cycle MISPREDICT=1, REDIRECT_PC=0x80. Then IF_PC=0x100 -> PRED_TAKEN=1, PRED_TARGET=0x80.
- Counter saturation: at 0x100 resolve not-taken three times from ctr=10 -> ctr path 01, 00, 00. PRED_TAKEN=0 after the first. Then two taken resolves are needed before PRED_TAKEN=1 again.
- Target change: JALR at 0x200 predicted taken to 0x300, resolves to 0x340 -> MISPREDICT=1, REDIRECT_PC=0x340. Entry target updated to 0x340.
- Alias: entry for 0x040 present; non-branch at 0x440 (same index, different tag) with EX_PRED_TAKEN=1 -> MISPREDICT=1, REDIRECT_PC=0x444. The 0x040 entry stays (tag mismatch). A non-branch at 0x040 with a hit invalidates it.
- Wrap and bubble: taken-predicted branch at 0xFFFFFFFC resolves not-taken -> REDIRECT_PC=0x00000000. The same inputs with EX_VALID=0 -> no pulse, no table change.
- RESET asserted mid-cycle during a mispredicting EX -> MISPREDICT=0 immediately. After release, all lookups miss.
